// File: rtl/uart_frame_decoder.sv
// Frame decoder behind a UART receiver: SOF, LEN, payload, XOR checksum.
// Buffers a verified payload and streams it out over valid/ready with a last marker.
module uart_frame_decoder #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dataValid,
    input  logic [7:0] Bite,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outLast,
    output logic       frameOk,
    output logic       frameErr,
    output logic [2:0] errCode
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [IW-1:0] ONE_IW    = IW'(1);
    localparam logic [TW-1:0] ONE_TW    = TW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    err_code_q, err_code_d;

    logic [7:0]    mem_q [MAX_LEN];
    logic          mem_we_s;

    logic          in_frame_s;
    logic          tmo_hit_s;
    logic          len_bad_s;
    logic          pay_last_s;
    logic          csum_ok_s;
    logic          xfer_s;
    logic [IW-1:0] rd_nxt_s;

    assign in_frame_s = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte arriving in the terminal-count cycle takes precedence over the timeout.
    assign tmo_hit_s  = in_frame_s && !dataValid && (tmo_q == TMO_LAST);
    assign len_bad_s  = (Bite == 8'd0) || (Bite > MAX_LEN_B);
    assign pay_last_s = (wr_idx_q == (len_q - ONE_IW));
    assign csum_ok_s  = (Bite == csum_q);
    assign xfer_s     = out_valid_q && outReady;
    assign rd_nxt_s   = rd_idx_q + ONE_IW;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (dataValid && (Bite == SOF_BYTE)) state_d = S_LEN;
                else                                 state_d = S_IDLE;
            end
            S_LEN: begin
                if (dataValid)      state_d = len_bad_s ? S_IDLE : S_PAYLOAD;
                else if (tmo_hit_s) state_d = S_IDLE;
                else                state_d = S_LEN;
            end
            S_PAYLOAD: begin
                if (dataValid)      state_d = pay_last_s ? S_CHECK : S_PAYLOAD;
                else if (tmo_hit_s) state_d = S_IDLE;
                else                state_d = S_PAYLOAD;
            end
            S_CHECK: begin
                if (dataValid)      state_d = csum_ok_s ? S_DRAIN : S_IDLE;
                else if (tmo_hit_s) state_d = S_IDLE;
                else                state_d = S_CHECK;
            end
            S_DRAIN: begin
                if (xfer_s && out_last_q) state_d = S_IDLE;
                else                      state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        mem_we_s    = 1'b0;

        if (in_frame_s) begin
            if (dataValid)      tmo_d = '0;
            else if (tmo_hit_s) tmo_d = '0;
            else                tmo_d = tmo_q + ONE_TW;
        end else begin
            tmo_d = tmo_q;
        end

        if (tmo_hit_s) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else begin
            frame_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (dataValid && (Bite == SOF_BYTE)) begin
                    csum_d = 8'd0;
                    tmo_d  = '0;
                end else begin
                    csum_d = csum_q;
                end
            end
            S_LEN: begin
                if (dataValid && len_bad_s) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_LEN;
                end else if (dataValid) begin
                    len_d    = Bite[IW-1:0];
                    csum_d   = Bite;
                    wr_idx_d = '0;
                end else begin
                    len_d = len_q;
                end
            end
            S_PAYLOAD: begin
                if (dataValid) begin
                    mem_we_s = 1'b1;
                    csum_d   = csum_q ^ Bite;
                    wr_idx_d = wr_idx_q + ONE_IW;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            S_CHECK: begin
                if (dataValid && csum_ok_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[{AW{1'b0}}];
                    out_last_d  = (len_q == ONE_IW);
                    rd_idx_d    = '0;
                end else if (dataValid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_CSUM;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            S_DRAIN: begin
                // Bytes arriving while draining are dropped; the buffer is untouched.
                if (dataValid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end else begin
                    err_code_d = err_code_q;
                end
                if (xfer_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    frame_ok_d  = 1'b1;
                end else if (xfer_s) begin
                    rd_idx_d   = rd_nxt_s;
                    out_data_d = mem_q[rd_nxt_s[AW-1:0]];
                    out_last_d = (rd_nxt_s == (len_q - ONE_IW));
                end else begin
                    out_data_d = out_data_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            csum_q      <= 8'd0;
            tmo_q       <= '0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[wr_idx_q[AW-1:0]] <= Bite;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign outLast  = out_last_q;
    assign frameOk  = frame_ok_q;
    assign frameErr = frame_err_q;
    assign errCode  = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: a vector table of whole frames plus
// hand-written sequences for timeout, overrun, reset and back-to-back corners.
module tb_uart_frame_decoder;

    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dataValid;
    logic [7:0] Bite;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       outLast;
    logic       frameOk;
    logic       frameErr;
    logic [2:0] errCode;

    always #5 clk = ~clk;

    uart_frame_decoder #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(T)) dut (
        .clk(clk), .rst_n(rst_n), .dataValid(dataValid), .Bite(Bite),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .outLast(outLast), .frameOk(frameOk), .frameErr(frameErr), .errCode(errCode)
    );

    typedef struct {
        string       name;
        bit          rst_first;
        int          nb;
        logic [63:0] bytes;   // first byte in the top bits
        logic [15:0] pat;     // outReady pattern while outValid, first bit on top
        int          plen;
        int          ne;
        logic [31:0] exp_v;   // expected payload, first byte in the top bits
        int          eok;
        int          eerr;
        logic [2:0]  code;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         ok_cnt, err_cnt, last_cnt;
    logic [7:0] last_byte;
    bit         valid_seen;
    bit         prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    vec_t       vecs[8];

    function automatic vec_t mk(input string nm, input bit rf, input int nb, input logic [63:0] b,
                                input logic [15:0] pat, input int plen, input int ne,
                                input logic [31:0] e, input int eok, input int eerr,
                                input logic [2:0] code);
        vec_t v;
        v.name = nm; v.rst_first = rf; v.nb = nb; v.bytes = b; v.pat = pat; v.plen = plen;
        v.ne = ne; v.exp_v = e; v.eok = eok; v.eerr = eerr; v.code = code;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // One clock: observe the current cycle, then advance to just after the edge.
    task automatic step();
        if (rst_n && prev_valid && !prev_ready)
            chk("hold", {54'd0, outValid, outLast, outData}, {54'd0, 1'b1, prev_last, prev_data});
        if (outValid && outReady) begin
            got_q.push_back(outData);
            if (outLast) begin
                last_cnt++;
                last_byte = outData;
            end
        end
        if (outValid) valid_seen = 1'b1;
        if (frameOk)  ok_cnt++;
        if (frameErr) err_cnt++;
        prev_valid = outValid;
        prev_ready = outReady;
        prev_last  = outLast;
        prev_data  = outData;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        ok_cnt = 0; err_cnt = 0; last_cnt = 0; last_byte = 8'd0; valid_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dataValid = 1'b0; Bite = 8'd0; outReady = 1'b1;
        step();
        rst_n = 1'b1;
        prev_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        dataValid = 1'b1;
        Bite = b;
        step();
        dataValid = 1'b0;
        Bite = 8'd0;
    endtask

    task automatic drain(input int n, input logic [15:0] pat, input int plen);
        int k = 0;
        repeat (n) begin
            if (outValid) begin
                outReady = (k < plen) ? pat[15-k] : 1'b1;
                k++;
            end else begin
                outReady = 1'b1;
            end
            step();
        end
        outReady = 1'b1;
    endtask

    task automatic check_frame(input string nm, input int eok, input int eerr, input logic [2:0] code);
        chk({nm, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk({nm, ".byte"}, {56'd0, got_q[i]}, {56'd0, exp_q[i]});
        chk({nm, ".last_cnt"}, 64'(last_cnt), 64'(eok));
        if (exp_q.size() > 0)
            chk({nm, ".last_byte"}, {56'd0, last_byte}, {56'd0, exp_q[exp_q.size()-1]});
        chk({nm, ".ok"}, 64'(ok_cnt), 64'(eok));
        chk({nm, ".err"}, 64'(err_cnt), 64'(eerr));
        chk({nm, ".code"}, {61'd0, errCode}, {61'd0, code});
        chk({nm, ".valid_seen"}, {63'd0, valid_seen}, {63'd0, exp_q.size() > 0});
        chk({nm, ".idle"}, {63'd0, outValid}, 64'd0);
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] b;

        vecs[0] = mk("good",      1'b1, 7, 64'h3CA5_0311_2233_0300, 16'h0000, 0, 3, 32'h1122_3300, 1, 0, 3'd0);
        vecs[1] = mk("backpress", 1'b1, 6, 64'hA503_1122_3303_0000, 16'h9400, 6, 3, 32'h1122_3300, 1, 0, 3'd0);
        vecs[2] = mk("csum_err",  1'b1, 5, 64'hA502_AA55_0000_0000, 16'h0000, 0, 0, 32'h0,         0, 1, 3'd2);
        vecs[3] = mk("after_cs",  1'b0, 6, 64'hA503_1122_3303_0000, 16'h0000, 0, 3, 32'h1122_3300, 1, 0, 3'd2);
        vecs[4] = mk("len_zero",  1'b1, 2, 64'hA500_0000_0000_0000, 16'h0000, 0, 0, 32'h0,         0, 1, 3'd1);
        vecs[5] = mk("len_17",    1'b0, 2, 64'hA511_0000_0000_0000, 16'h0000, 0, 0, 32'h0,         0, 1, 3'd1);
        vecs[6] = mk("len_one",   1'b0, 4, 64'hA501_7E7F_0000_0000, 16'h0000, 0, 1, 32'h7E00_0000, 1, 0, 3'd1);
        vecs[7] = mk("sof_in_pl", 1'b1, 7, 64'h00FF_A502_A5A5_0200, 16'h0000, 0, 2, 32'hA5A5_0000, 1, 0, 3'd0);

        rst_n = 1'b1; dataValid = 1'b0; Bite = 8'd0; outReady = 1'b1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = 8'd0;
        clear_obs();

        do_reset();
        chk("reset_state", {48'd0, outValid, outLast, frameOk, frameErr, 1'b0, errCode, outData}, 64'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_first) do_reset();
            clear_obs();
            for (int i = 0; i < vecs[v].ne; i++) exp_q.push_back(vecs[v].exp_v[31-8*i -: 8]);
            for (int i = 0; i < vecs[v].nb; i++) send(vecs[v].bytes[63-8*i -: 8]);
            drain(24, vecs[v].pat, vecs[v].plen);
            check_frame(vecs[v].name, vecs[v].eok, vecs[v].eerr, vecs[v].code);
        end

        // Timeout fires after T idle cycles inside a frame.
        do_reset(); clear_obs();
        send(8'hA5); send(8'h02); send(8'hAA);
        repeat (T - 1) step();
        chk("tmo.early", {60'd0, frameErr, errCode}, 64'd0);
        step();
        chk("tmo.fire", {60'd0, frameErr, errCode}, {60'd0, 1'b1, 3'd3});
        drain(4, 16'h0000, 0);
        clear_obs();
        exp_q.push_back(8'h7E);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        drain(12, 16'h0000, 0);
        check_frame("after_tmo", 1, 0, 3'd3);

        // A byte on the terminal-count cycle wins over the timeout.
        do_reset(); clear_obs();
        send(8'hA5); send(8'h02); send(8'hAA);
        repeat (T - 1) step();
        send(8'hAA);
        chk("notmo.edge", {60'd0, frameErr, errCode}, 64'd0);
        send(8'h02);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
        drain(12, 16'h0000, 0);
        check_frame("notmo", 1, 0, 3'd0);

        // Overrun: byte injected while a byte is held under backpressure.
        do_reset(); clear_obs();
        outReady = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        send(8'h5A);
        chk("ovr.pulse", {50'd0, frameErr, errCode, outValid, outData},
            {50'd0, 1'b1, 3'd4, 1'b1, 8'h11});
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        drain(12, 16'h0000, 0);
        check_frame("overrun", 1, 1, 3'd4);

        // Reset in the middle of a payload clears errCode and emits nothing.
        clear_obs();
        send(8'hA5); send(8'h04); send(8'h01);
        rst_n = 1'b0;
        step();
        chk("midrst", {48'd0, outValid, outLast, frameOk, frameErr, 1'b0, errCode, outData}, 64'd0);
        rst_n = 1'b1;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        drain(12, 16'h0000, 0);
        check_frame("after_rst", 1, 0, 3'd0);

        // SOF arriving in the frameOk cycle starts the next frame.
        do_reset(); clear_obs();
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        step();
        chk("b2b.ok_cycle", {62'd0, frameOk, outValid}, {62'd0, 1'b1, 1'b0});
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        exp_q.push_back(8'h7E); exp_q.push_back(8'h7E);
        drain(12, 16'h0000, 0);
        check_frame("b2b", 2, 0, 3'd0);

        // Maximum-length payload.
        do_reset(); clear_obs();
        cs = 8'h10;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 37 + 5);
            exp_q.push_back(b);
            cs = cs ^ b;
            send(b);
        end
        send(cs);
        drain(30, 16'h0000, 0);
        check_frame("maxlen", 1, 0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Sits directly downstream of the UART receiver and consumes its one-cycle dataValid strobe and Bite byte. Parses the byte stream into frames of the form SOF, LEN, LEN payload bytes, then an XOR checksum byte. Payloads are buffered internally, then streamed out over a valid/ready interface with a last marker. Malformed, stalled or overrun frames are reported with a pulse and a sticky error code.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload length in bytes (1..255); also the payload buffer depth.
TIMEOUT_CLKS, 1000, maximum clk cycles allowed between consecutive bytes inside a frame.

Ports:
clk  in  1  single system clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
dataValid  in  1  one-cycle strobe from the receiver: Bite is valid.
Bite  in  8  received byte.
outData  out  8  payload byte being presented.
outValid  out  1  outData is valid.
outReady  in  1  downstream accepts outData this cycle.
outLast  out  1  high with the final payload byte of a frame.
frameOk  out  1  one-cycle pulse: frame fully delivered.
frameErr  out  1  one-cycle pulse: error detected.
errCode  out  3  last error, sticky: 0 none, 1 LEN, 2 CSUM, 3 TIMEOUT, 4 OVERRUN.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; outValid, outLast, frameOk, frameErr and errCode = 0; outData = 0; all counters = 0. Buffer contents are not reset. Reset mid-frame discards the frame silently, with no error pulse.
- Checksum register csum is 8 bits: csum = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
- IDLE: a dataValid with Bite==SOF_BYTE goes to LEN and clears csum and the timeout counter. All other bytes are ignored without error.
- LEN: on dataValid, if Bite==0 or Bite>MAX_LEN: frameErr pulse, errCode=1, go to IDLE. Otherwise latch len=Bite, set csum=Bite, set wrIdx=0, go to PAYLOAD.
- PAYLOAD: on dataValid, buf[wrIdx]=Bite, csum^=Bite, wrIdx++. After byte number len, go to CHECK.
- CHECK: on dataValid, if Bite==csum go to DRAIN with rdIdx=0. Otherwise frameErr pulse, errCode=2, go to IDLE.
- DRAIN:
  - outValid=1, outData=buf[rdIdx], outLast=(rdIdx==len-1). All outputs are registered.
  - outValid rises the cycle after the checksum byte's dataValid cycle.
  - A transfer occurs when outValid && outReady; rdIdx then increments.
  - outData and outLast hold stable while outReady is low.
  - On the last transfer's edge: outValid=0, outLast=0, frameOk pulses the following cycle, and the state returns to IDLE. A SOF arriving in that frameOk cycle is accepted.
  - Back-to-back transfers run at one byte per cycle.
- Overrun: a dataValid during DRAIN drops the byte, pulses frameErr, and sets errCode=4. DRAIN continues and buffered data is unaffected.
- Timeout: in LEN, PAYLOAD and CHECK, a counter increments on each cycle without dataValid and clears on dataValid. When it reaches TIMEOUT_CLKS-1: frameErr pulse, errCode=3, go to IDLE. If dataValid and the terminal count coincide, the byte wins and there is no timeout. The counter is idle in IDLE and DRAIN.
- dataValid may be asserted on consecutive cycles; every strobe must be processed.
- errCode changes only on a new error or reset. frameOk does not clear it.
- Counter widths: wrIdx/rdIdx/len use clog2(MAX_LEN+1) bits; the timeout counter uses clog2(TIMEOUT_CLKS) bits, with no wrap before the terminal count.

Test Plan:
- Good frame, outReady=1: bytes 3C, A5, 03, 11, 22, 33, 03 -> 3C ignored; outData 11, 22, 33 on three consecutive cycles; outLast with 33; one frameOk pulse; frameErr never asserted; errCode=0.
- Backpressure: same frame with outReady toggling 1,0,0,1,0,1 -> each byte held stable while outReady is low; exactly 11, 22, 33 delivered in order; a single frameOk.
- Checksum error: A5, 02, AA, 55, 00 (expected FD) -> frameErr pulse, errCode=2, outValid never set; a following good frame decodes normally.
- Length error: A5, 00 -> errCode=1. Then A5, 11 (17 > MAX_LEN) -> errCode=1. State returns to IDLE both times; no payload output.
- Timeout and overrun:
  - A5, 02, AA, then no bytes for TIMEOUT_CLKS cycles -> frameErr, errCode=3.
  - In a separate run, a byte arrives on TIMEOUT_CLKS-1 exactly -> no timeout.
  - A byte injected during DRAIN -> errCode=4, with output bytes unchanged.
- Reset mid-PAYLOAD: rst_n low for one cycle after A5, 04, 01 -> all outputs 0, errCode=0; the next full frame decodes correctly.
